inout_bus_ctrl: RTL and testbench
=================================

Name: inout_bus_ctrl

Overview:
- Parametrised bidirectional pad controller; successor to the fixed 16-bit registered inout set.
- Adds direction arbitration, a guard (turnaround) window on every direction change, a configurable input synchroniser depth and a valid-strobed read path.
- Sits between a design-side request interface and shared external bus pins such as SRAM or a parallel LCD data bus.
- All pad-facing signals are registered, so the pins never see combinational glitches.

Parameters:
- WIDTH, 16, bus width in bits.
- SYNC_STAGES, 1, number of input capture flops (at least 1); sets read latency.
- TURNAROUND, 1, hi-Z guard cycles inserted after each write or read burst (0 to 15).

Ports:
- clock  input  1  single clock; every flop is clocked on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_pin  inout  WIDTH  external bus pins.
- wr_data  input  WIDTH  data to drive.
- wr_req  input  1  write beat request.
- wr_ready  output  1  write beat accepted this cycle when wr_req and wr_ready are both high.
- rd_req  input  1  read beat request.
- rd_ready  output  1  read beat accepted this cycle when rd_req and rd_ready are both high.
- rd_data  output  WIDTH  captured pin value.
- rd_valid  output  1  one-cycle strobe qualifying rd_data.
- busy  output  1  high whenever state is not IDLE or a read is in flight.

Behaviour:
- States are IDLE, WRITE, READ and TURN. A 4-bit turnaround counter supports TURNAROUND up to 15.
- Reset values:
  - state is IDLE, oe_q is 0 so the pins are hi-Z, and ff_write is 0.
  - The synchroniser flops, rd_data and the valid delay line are all 0.
  - rd_valid and busy are 0.
- Ready signals are combinational from state and requests:
  - rd_ready is high in IDLE and in READ.
  - wr_ready is high in IDLE when rd_req is low, and in WRITE.
- Simultaneous requests in IDLE: the read wins and the write waits.
- Write path:
  - An accepted beat loads ff_write with wr_data and sets oe_q to 1.
  - The pins are driven during the following cycle only, one cycle per beat, so the write latency is 1.
  - Back-to-back beats give continuous driving.
  - A cycle in WRITE with no accepted beat clears oe_q, and the state moves to TURN.
- Read path:
  - The first synchroniser flop samples io_pin on every edge.
  - An accepted beat pushes a 1 into a valid delay line of length SYNC_STAGES.
  - rd_valid fires exactly SYNC_STAGES cycles after the acceptance cycle.
  - rd_data equals the io_pin value present during the acceptance cycle.
  - Pipelined back-to-back reads give one strobe per beat.
- Leaving READ: a cycle in READ with no accepted beat moves the state to TURN. A read already in the delay line still completes.
- Direction change: a rd_req while in WRITE, or a wr_req while in READ, is not accepted. The state goes to TURN, and the request is served from IDLE.
- TURN:
  - The pins are hi-Z and both ready signals are low.
  - The counter loads TURNAROUND-1 on entry and the state moves to IDLE when it reaches 0.
  - With TURNAROUND=0, TURN is skipped: WRITE or READ goes directly to IDLE.
- Reset mid-operation (synchronous): oe_q is 0 after the edge, any pending rd_valid strobes are dropped, and the state is IDLE.
- io_pin is ff_write when oe_q is 1, otherwise all Z.

Optional Feature:
- Macro: INOUT_BUS_OE_MASK_EN.
- When defined:
  - Adds port wr_mask, input, WIDTH.
  - wr_mask is registered with each accepted write beat.
  - Bit i is driven only when oe_q and the registered mask bit i are both 1; all other bits are Z.
  - Reads are unaffected.
- When undefined: the port is absent and all bits share a single oe_q.

Test Plan:
1. Reset, then three write beats 0xA5A5, 0x1234, 0xFFFF -> the pins show these values in cycles 1, 2 and 3 after the first acceptance, are hi-Z in cycle 4, wr_ready is low for 1 TURN cycle, then the state is IDLE.
2. With SYNC_STAGES=2, the external driver sets 0x0F0F and one rd_req is issued -> rd_valid is high exactly 2 cycles later with rd_data=0x0F0F. Four back-to-back reads give four consecutive strobes.
3. wr_req and rd_req are high together in IDLE -> only rd_ready is high. The read completes, TURNAROUND=3 gives 3 hi-Z cycles, then the write is accepted.
4. In WRITE, rd_req rises while wr_req falls -> rd_ready stays 0 through TURN. There is no cycle where oe_q=1 and a read is accepted.
5. Reset asserted during a write burst and with a read in flight -> the pins are hi-Z the next cycle, no rd_valid strobe appears, and busy=0.
6. With INOUT_BUS_OE_MASK_EN, write 0xBEEF with mask 0x00FF -> the upper byte is Z and the lower byte reads 0xEF.

Source files
------------

// File: rtl/inout_bus_ctrl.sv
// inout_bus_ctrl: parametrised bidirectional pad controller.
// Arbitrates bus direction between a write and a read request stream,
// inserts a hi-Z guard window on every direction change, captures the
// pins through SYNC_STAGES flops and strobes each read beat with rd_valid.
// All pad-facing signals come straight from flops.
// Optional build macro: INOUT_BUS_OE_MASK_EN adds a per-bit write mask
// (wr_mask) so that only selected bits are driven during a write beat.
module inout_bus_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 1,   // must be >= 1
    parameter int TURNAROUND  = 1    // 0..15
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] io_pin,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_req,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
`ifdef INOUT_BUS_OE_MASK_EN
    ,
    input  logic [WIDTH-1:0] wr_mask
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    // Counter preload on TURN entry; TURN lasts TA_LOAD+1 cycles.
    localparam logic [3:0] TA_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    // With no guard window a finished burst drops straight back to IDLE.
    localparam logic [1:0] S_AFTER = (TURNAROUND > 0) ? S_TURN : S_IDLE;

    logic [1:0]                        state_q, state_d;
    logic [3:0]                        cnt_q, cnt_d;
    logic                              oe_q, oe_d;
    logic [WIDTH-1:0]                  ff_write_q, ff_write_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0]            vld_q;
    logic                              wr_acc, rd_acc;

    // Handshakes: reads win over writes in IDLE, TURN blocks both.
    assign rd_ready = (state_q == S_IDLE) || (state_q == S_READ);
    assign wr_ready = ((state_q == S_IDLE) && !rd_req) || (state_q == S_WRITE);
    assign wr_acc   = wr_req & wr_ready;
    assign rd_acc   = rd_req & rd_ready;

    // Direction FSM and turnaround counter next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rd_acc)      state_d = S_READ;
                else if (wr_acc) state_d = S_WRITE;
            end
            S_WRITE: begin
                // A missing beat (idle or a read asking for the bus) ends the burst.
                if (!wr_acc) begin
                    state_d = S_AFTER;
                    cnt_d   = TA_LOAD;
                end
            end
            S_READ: begin
                if (!rd_acc) begin
                    state_d = S_AFTER;
                    cnt_d   = TA_LOAD;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Each accepted beat drives the pins for exactly the following cycle.
    assign oe_d       = wr_acc;
    assign ff_write_d = wr_acc ? wr_data : ff_write_q;

    // FSM, counter and write-side output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            oe_q       <= 1'b0;
            ff_write_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            ff_write_q <= ff_write_d;
        end
    end

    // Input capture chain and matching valid delay line; the first flop
    // samples the pins every cycle, so data and valid stay aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q[0] <= io_pin;
            vld_q[0]  <= rd_acc;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign rd_data  = sync_q[SYNC_STAGES-1];
    assign rd_valid = vld_q[SYNC_STAGES-1];
    assign busy     = (state_q != S_IDLE) || (|vld_q);

`ifdef INOUT_BUS_OE_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    assign mask_d = wr_acc ? wr_mask : mask_q;

    // Mask is captured alongside the data of each accepted beat.
    always_ff @(posedge clock) begin
        if (reset) mask_q <= '0;
        else       mask_q <= mask_d;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign io_pin[g] = (oe_q && mask_q[g]) ? ff_write_q[g] : 1'bz;
    end
`else
    assign io_pin = oe_q ? ff_write_q : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_inout_bus_ctrl.sv
// Bench for inout_bus_ctrl (WIDTH=16, SYNC_STAGES=2, TURNAROUND=3).
// The bus carries a weak pulldown, so an undriven pin reads 0; all data
// patterns written by the DUT are non-zero.
module tb_inout_bus_ctrl;
    localparam int W  = 16;
    localparam int SS = 2;
    localparam int TA = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] wr_data = '0;
    logic         wr_req = 1'b0;
    logic         rd_req = 1'b0;
    logic         wr_ready, rd_ready, rd_valid, busy;
    logic [W-1:0] rd_data;
    logic         ext_oe = 1'b0;
    logic [W-1:0] ext_val = '0;
    logic [W-1:0] wr_mask = 16'hFFFF;
    wire  [W-1:0] io_pin;

    assign io_pin = ext_oe ? ext_val : {W{1'bz}};
    for (genvar g = 0; g < W; g++) begin : g_pd
        pulldown (io_pin[g]);
    end

    inout_bus_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .TURNAROUND(TA)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_pin   (io_pin),
        .wr_data  (wr_data),
        .wr_req   (wr_req),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
`ifdef INOUT_BUS_OE_MASK_EN
        ,
        .wr_mask  (wr_mask)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] wd;
        bit           eoe;
        logic [W-1:0] ev;
        bit           xwr;   // expected wr_ready
        bit           xrd;   // expected rd_ready
        bit           xbusy; // expected busy
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } exp_t;

    vec_t tbl[$];
    exp_t wq[$];
    exp_t rq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input bit wr, input bit rd, input logic [W-1:0] wd, input bit eoe,
                       input logic [W-1:0] ev, input bit xw, input bit xr, input bit xb);
        vec_t v;
        v = '{wr, rd, wd, eoe, ev, xw, xr, xb};
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic step(input bit wr, input bit rd, input logic [W-1:0] wd, input bit eoe,
                        input logic [W-1:0] ev, input bit rst);
        @(posedge clock);
        #1;
        wr_req  = wr;
        rd_req  = rd;
        wr_data = wd;
        ext_oe  = eoe;
        ext_val = ev;
        reset   = rst;
        @(negedge clock);
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_pin_hiz", 32'(io_pin), 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rd_data", 32'(rd_data), 32'h0);

        // ---- per-cycle vectors: wr rd wd eoe ev | wr_ready rd_ready busy ----
        // three-beat write burst, then TA turn cycles
        row(1, 0, 16'hA5A5, 0, 16'h0, 1, 1, 0);
        row(1, 0, 16'h1234, 0, 16'h0, 1, 0, 1);
        row(1, 0, 16'hFFFF, 0, 16'h0, 1, 0, 1);
        row(0, 0, 16'h0,    0, 16'h0, 1, 0, 1);
        repeat (TA) row(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        row(0, 0, 16'h0,    0, 16'h0, 1, 1, 0);
        // single read of an externally driven 0x0F0F
        row(0, 1, 16'h0,    1, 16'h0F0F, 0, 1, 0);
        row(0, 0, 16'h0,    1, 16'h0F0F, 0, 1, 1);
        repeat (TA) row(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        // four back-to-back reads
        row(0, 1, 16'h0,    1, 16'h1111, 0, 1, 0);
        row(0, 1, 16'h0,    1, 16'h2222, 0, 1, 1);
        row(0, 1, 16'h0,    1, 16'h3333, 0, 1, 1);
        row(0, 1, 16'h0,    1, 16'h4444, 0, 1, 1);
        row(0, 0, 16'h0,    0, 16'h0,    0, 1, 1);
        repeat (TA) row(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        // simultaneous requests: read first, write after the guard window
        row(1, 1, 16'hC0DE, 1, 16'h5A5A, 0, 1, 0);
        row(1, 0, 16'hC0DE, 0, 16'h0,    0, 1, 1);
        repeat (TA) row(1, 0, 16'hC0DE, 0, 16'h0, 0, 0, 1);
        row(1, 0, 16'hC0DE, 0, 16'h0,    1, 1, 0);
        row(0, 0, 16'h0,    0, 16'h0,    1, 0, 1);
        repeat (TA) row(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        // read requested while in WRITE: waits out TURN
        row(1, 0, 16'hBEEF, 0, 16'h0,    1, 1, 0);
        row(0, 1, 16'h0,    0, 16'h0,    1, 0, 1);
        repeat (TA) row(0, 1, 16'h0, 0, 16'h0, 0, 0, 1);
        row(0, 1, 16'h0,    1, 16'h7777, 0, 1, 0);
        row(0, 0, 16'h0,    0, 16'h0,    0, 1, 1);
        repeat (TA) row(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        row(0, 0, 16'h0,    0, 16'h0,    1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            step(tbl[i].wr, tbl[i].rd, tbl[i].wd, tbl[i].eoe, tbl[i].ev, 1'b0);
            chk($sformatf("wr_ready[%0d]", i), 32'(wr_ready), 32'(tbl[i].xwr));
            chk($sformatf("rd_ready[%0d]", i), 32'(rd_ready), 32'(tbl[i].xrd));
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'(tbl[i].xbusy));
            // pins: driven write data when a beat is due, else only the external driver
            if (wq.size() > 0 && wq[0].due == i) begin
                chk($sformatf("pin_wr[%0d]", i), 32'(io_pin), 32'(wq[0].val));
                void'(wq.pop_front());
            end else begin
                chk($sformatf("pin_hiz[%0d]", i), 32'(io_pin), 32'(tbl[i].eoe ? tbl[i].ev : 16'h0));
            end
            // read strobes
            if (rq.size() > 0 && rq[0].due == i) begin
                chk($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'h1);
                chk($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(rq[0].val));
                void'(rq.pop_front());
            end else begin
                chk($sformatf("rd_idle[%0d]", i), 32'(rd_valid), 32'h0);
            end
            // scoreboard pushes on handshake
            if (wr_req && wr_ready) begin
                e.due = i + 1;
                e.val = tbl[i].wd;
                wq.push_back(e);
            end
            if (rd_req && rd_ready) begin
                e.due = i + SS;
                e.val = tbl[i].eoe ? tbl[i].ev : 16'h0;
                rq.push_back(e);
            end
        end
        chk("wq_drained", 32'(wq.size()), 32'h0);
        chk("rq_drained", 32'(rq.size()), 32'h0);

        // ---- reset during a write burst ----
        step(1, 0, 16'h1357, 0, 16'h0, 1'b0);
        chk("rst_w_accept", 32'(wr_ready), 32'h1);
        step(1, 0, 16'h2468, 0, 16'h0, 1'b0);
        chk("rst_w_pin1", 32'(io_pin), 32'h1357);
        step(1, 0, 16'h3579, 0, 16'h0, 1'b1);
        chk("rst_w_pin2", 32'(io_pin), 32'h2468);
        step(0, 0, 16'h0, 0, 16'h0, 1'b1);
        chk("rst_w_hiz", 32'(io_pin), 32'h0);
        chk("rst_w_busy", 32'(busy), 32'h0);
        chk("rst_w_rdv", 32'(rd_valid), 32'h0);
        step(0, 0, 16'h0, 0, 16'h0, 1'b0);
        chk("rst_w_hiz2", 32'(io_pin), 32'h0);
        chk("rst_w_idle", 32'(wr_ready), 32'h1);

        // ---- reset with a read in flight ----
        step(0, 1, 16'h0, 1, 16'hAAAA, 1'b0);
        chk("rst_r_accept", 32'(rd_ready), 32'h1);
        step(0, 0, 16'h0, 0, 16'h0, 1'b1);
        chk("rst_r_busy_pre", 32'(busy), 32'h1);
        step(0, 0, 16'h0, 0, 16'h0, 1'b0);
        chk("rst_r_nostrobe", 32'(rd_valid), 32'h0);
        chk("rst_r_busy", 32'(busy), 32'h0);
        step(0, 0, 16'h0, 0, 16'h0, 1'b0);
        chk("rst_r_nostrobe2", 32'(rd_valid), 32'h0);

`ifdef INOUT_BUS_OE_MASK_EN
        // ---- masked write: only the low byte is driven ----
        wr_mask = 16'h00FF;
        step(1, 0, 16'hBEEF, 0, 16'h0, 1'b0);
        chk("mask_accept", 32'(wr_ready), 32'h1);
        wr_mask = 16'hFFFF;
        step(0, 0, 16'h0, 0, 16'h0, 1'b0);
        chk("mask_pin", 32'(io_pin), 32'h00EF);
        repeat (TA + 1) step(0, 0, 16'h0, 0, 16'h0, 1'b0);
        chk("mask_hiz", 32'(io_pin), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
